// File: rtl/ad_cache_rd_ctrl.sv
// Cache read controller: generates cache EN/SYNC, reads each finished ping-pong
// half in SUB_WORDS bursts and streams the words into the USB FIFO.
//
// state | meaning
// IDLE  | acquisition disabled, waiting for o_en
// ARM   | enabled, waiting for the cache to switch halves
// BURST | o_rd high, one cache word = SUB_WORDS reads
// CHECK | word boundary: count word, honour FIFO backpressure
// DRAIN | wait for in-flight reads to reach the FIFO, then count the block
module ad_cache_rd_ctrl #(
   parameter int HALF_WORDS  = 512,
   parameter int SUB_WORDS   = 3,
   parameter int RD_LAT      = 2,
   parameter int SYNC_PERIOD = 50000,
   parameter int SYNC_WIDTH  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_run,
   output logic        o_en,
   output logic        o_sync,
   input  logic        i_switch,
   output logic        o_rd,
   input  logic [15:0] i_rdata,
   output logic        o_fifo_wr,
   output logic [15:0] o_fifo_wdata,
   input  logic        i_fifo_afull,
   output logic        o_busy,
   output logic        o_ovf,
   input  logic        i_ovf_clr,
   output logic [15:0] o_frame_cnt
);

   localparam int SYNC_W = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
   localparam int WORD_W = $clog2(HALF_WORDS + 1);
   localparam int SUB_W  = $clog2(SUB_WORDS + 1);
   localparam int DRN_W  = $clog2(RD_LAT + 1);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ARM   = 3'd1;
   localparam logic [2:0] BURST = 3'd2;
   localparam logic [2:0] CHECK = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
   logic [SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
   logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
   logic [15:0]       frame_q, frame_d;
   logic              ovf_q, ovf_d;
   logic              en_q, sw_q;
   logic              sync_run_q;
   logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
   logic              sync_q, sync_d;
   logic [RD_LAT:1]   rd_pipe_q, rd_pipe_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              sw_evt, last_sub, last_word;

   assign sw_evt    = (sw_q != i_switch);
   assign last_sub  = (sub_cnt_q == SUB_W'(SUB_WORDS - 1));
   assign last_word = (word_cnt_q == WORD_W'(HALF_WORDS - 1));
   assign o_rd      = (state_q == BURST);
   assign o_busy    = (state_q == BURST) || (state_q == CHECK) || (state_q == DRAIN);

   // sync_run_q holds the counter for one cycle after reset so SYNC first rises on the 2nd edge
   always_comb begin
      sync_cnt_d = sync_cnt_q;
      if (sync_run_q) begin
         sync_cnt_d = (sync_cnt_q == SYNC_W'(SYNC_PERIOD - 1)) ? '0 : sync_cnt_q + SYNC_W'(1);
      end
      sync_d = sync_run_q && (sync_cnt_q < SYNC_W'(SYNC_WIDTH));
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      sub_cnt_d  = sub_cnt_q;
      drn_cnt_d  = drn_cnt_q;
      frame_d    = frame_q;
      ovf_d      = i_ovf_clr ? 1'b0 : ovf_q;
      case (state_q)
         IDLE: begin
            if (en_q) state_d = ARM;
         end
         ARM: begin
            if (sw_evt) begin
               state_d    = BURST;
               word_cnt_d = '0;
               sub_cnt_d  = '0;
            end else if (!en_q) begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (last_sub) state_d = CHECK;
            else          sub_cnt_d = sub_cnt_q + SUB_W'(1);
         end
         CHECK: begin
            if (last_word) begin
               state_d    = DRAIN;
               word_cnt_d = word_cnt_q + WORD_W'(1);
               drn_cnt_d  = DRN_W'(RD_LAT - 1);
            end else if (!i_fifo_afull) begin
               state_d    = BURST;
               word_cnt_d = word_cnt_q + WORD_W'(1);
               sub_cnt_d  = '0;
            end
         end
         DRAIN: begin
            if (drn_cnt_q == '0) begin
               state_d = ARM;
               frame_d = frame_q + 16'd1;
            end else begin
               drn_cnt_d = drn_cnt_q - DRN_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      // Overrun: the cache flipped halves before this one was read out; restart on the new half
      if (o_busy && sw_evt) begin
         ovf_d      = 1'b1;
         state_d    = BURST;
         word_cnt_d = '0;
         sub_cnt_d  = '0;
         frame_d    = frame_q;
      end
   end

   always_comb begin
      rd_pipe_d[1] = o_rd;
      for (int i = 2; i <= RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
      wdata_d = rd_pipe_d[RD_LAT] ? i_rdata : wdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         sub_cnt_q  <= '0;
         drn_cnt_q  <= '0;
         frame_q    <= '0;
         ovf_q      <= 1'b0;
         en_q       <= 1'b0;
         sw_q       <= 1'b0;
         sync_run_q <= 1'b0;
         sync_cnt_q <= '0;
         sync_q     <= 1'b0;
         rd_pipe_q  <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         sub_cnt_q  <= sub_cnt_d;
         drn_cnt_q  <= drn_cnt_d;
         frame_q    <= frame_d;
         ovf_q      <= ovf_d;
         en_q       <= i_run;
         sw_q       <= i_switch;
         sync_run_q <= 1'b1;
         sync_cnt_q <= sync_cnt_d;
         sync_q     <= sync_d;
         rd_pipe_q  <= rd_pipe_d;
         wdata_q    <= wdata_d;
      end
   end

   assign o_en         = en_q;
   assign o_sync       = sync_q;
   assign o_fifo_wr    = rd_pipe_q[RD_LAT];
   assign o_fifo_wdata = wdata_q;
   assign o_ovf        = ovf_q;
   assign o_frame_cnt  = frame_q;

endmodule

// File: tb/tb_ad_cache_rd_ctrl.sv
// Bench for ad_cache_rd_ctrl: a cache model feeds random read data, a scoreboard
// checks every FIFO write, and block-level expectations come from a simple model.
module tb_ad_cache_rd_ctrl;

   localparam int HW  = 4;
   localparam int SW  = 3;
   localparam int RL  = 2;
   localparam int SP  = 20;
   localparam int SWD = 2;
   localparam int BLK = HW * SW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_run = 1'b0;
   logic        o_en, o_sync;
   logic        i_switch = 1'b0;
   logic        o_rd;
   logic [15:0] i_rdata = '0;
   logic        o_fifo_wr;
   logic [15:0] o_fifo_wdata;
   logic        i_fifo_afull = 1'b0;
   logic        o_busy, o_ovf;
   logic        i_ovf_clr = 1'b0;
   logic [15:0] o_frame_cnt;

   ad_cache_rd_ctrl #(.HALF_WORDS(HW), .SUB_WORDS(SW), .RD_LAT(RL),
                      .SYNC_PERIOD(SP), .SYNC_WIDTH(SWD)) dut (
      .clk(clk), .rst_n(rst_n), .i_run(i_run), .o_en(o_en), .o_sync(o_sync),
      .i_switch(i_switch), .o_rd(o_rd), .i_rdata(i_rdata), .o_fifo_wr(o_fifo_wr),
      .o_fifo_wdata(o_fifo_wdata), .i_fifo_afull(i_fifo_afull), .o_busy(o_busy),
      .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr), .o_frame_cnt(o_frame_cnt));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int n_edge = 0;
   int run_len = 0;
   int frames_exp = 0;
   logic [15:0] exp_q[$];
   logic [RL:1] rd_hist = '0;
   logic        rd_dly = 1'b0;
   logic [15:0] dat_dly = '0;
   logic [15:0] dat_new;
   logic [15:0] dat_got;
   logic        en_ref = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   always @(posedge clk) en_ref = i_run;

   // Monitor + cache model: sample at negedge, far from the active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rd_hist = '0;
         rd_dly  = 1'b0;
         n_edge  = 0;
         run_len = 0;
      end else begin
         n_edge++;
         chk("sync", int'(o_sync), int'(n_edge >= 2 && ((n_edge - 2) % SP) < SWD));
         chk("en", int'(o_en), int'(en_ref));
         chk("fifo_wr_timing", int'(o_fifo_wr), int'(rd_hist[RL]));
         if (o_fifo_wr) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               dat_got = exp_q.pop_front();
               chk("fifo_wdata", int'(o_fifo_wdata), int'(dat_got));
            end
         end
         for (int k = RL; k >= 2; k--) rd_hist[k] = rd_hist[k-1];
         rd_hist[1] = o_rd;
         // cache presents data one cycle after the read so the DUT registers it RD_LAT edges later
         i_rdata = rd_dly ? dat_dly : 16'($urandom);
         if (o_rd) begin
            dat_new = 16'($urandom);
            exp_q.push_back(dat_new);
            rd_cnt++;
            rd_dly  = 1'b1;
            dat_dly = dat_new;
            run_len++;
         end else begin
            rd_dly = 1'b0;
            if (run_len != 0) chk("group_len", run_len, SW);
            run_len = 0;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_rd(input int target, input int budget);
      for (int i = 0; i < budget && rd_cnt < target; i++) cyc(1);
      chk("rd_reach", int'(rd_cnt >= target), 1);
   endtask

   task automatic wait_frame(input int target, input int budget);
      for (int i = 0; i < budget && int'(o_frame_cnt) != target; i++) cyc(1);
      chk("frame_cnt", int'(o_frame_cnt), target);
   endtask

   task automatic toggle();
      i_switch = ~i_switch;
   endtask

   int base;

   initial begin
      cyc(2);
      chk("rst_sync", int'(o_sync), 0);
      chk("rst_en", int'(o_en), 0);
      chk("rst_rd", int'(o_rd), 0);
      chk("rst_wr", int'(o_fifo_wr), 0);
      chk("rst_ovf", int'(o_ovf), 0);
      chk("rst_frame", int'(o_frame_cnt), 0);
      chk("rst_busy", int'(o_busy), 0);
      rst_n = 1'b1;

      // idle: SYNC runs, nothing is read
      base = rd_cnt;
      cyc(100);
      chk("idle_rd", rd_cnt - base, 0);
      chk("idle_en", int'(o_en), 0);

      // nominal block
      i_run = 1'b1;
      cyc(4);
      base = rd_cnt;
      toggle();
      cyc(3);
      chk("busy_mid", int'(o_busy), 1);
      frames_exp++;
      wait_frame(frames_exp, 200);
      chk("nom_reads", rd_cnt - base, BLK);
      chk("nom_ovf", int'(o_ovf), 0);
      chk("nom_sb_empty", exp_q.size(), 0);

      // backpressure after the 2nd word
      base = rd_cnt;
      toggle();
      wait_rd(base + 2 * SW, 100);
      i_fifo_afull = 1'b1;
      cyc(10);
      chk("bp_no_rd", rd_cnt - base, 2 * SW);
      i_fifo_afull = 1'b0;
      frames_exp++;
      wait_frame(frames_exp, 200);
      chk("bp_reads", rd_cnt - base, BLK);

      // overrun in CHECK after the 6th read; clear coincides with the set
      base = rd_cnt;
      toggle();
      wait_rd(base + 2 * SW, 100);
      cyc(1);
      toggle();
      i_ovf_clr = 1'b1;
      cyc(1);
      i_ovf_clr = 1'b0;
      chk("ovf_set_wins", int'(o_ovf), 1);
      frames_exp++;
      wait_frame(frames_exp, 200);
      chk("ovf_reads", rd_cnt - base, 2 * SW + BLK);
      chk("ovf_sticky", int'(o_ovf), 1);
      i_ovf_clr = 1'b1;
      cyc(1);
      i_ovf_clr = 1'b0;
      chk("ovf_clr", int'(o_ovf), 0);

      // reset at the 5th read of a block
      base = rd_cnt;
      toggle();
      wait_rd(base + 5, 100);
      rst_n = 1'b0;
      #1;
      chk("mrst_rd", int'(o_rd), 0);
      chk("mrst_wr", int'(o_fifo_wr), 0);
      chk("mrst_sync", int'(o_sync), 0);
      chk("mrst_en", int'(o_en), 0);
      chk("mrst_busy", int'(o_busy), 0);
      chk("mrst_ovf", int'(o_ovf), 0);
      chk("mrst_frame", int'(o_frame_cnt), 0);
      frames_exp = 0;
      cyc(2);
      rst_n = 1'b1;
      cyc(6);
      chk("mrst_after_busy", int'(o_busy), 0);

      // i_run dropped during word 2: block completes, then FSM parks in IDLE
      base = rd_cnt;
      toggle();
      wait_rd(base + SW + 1, 100);
      i_run = 1'b0;
      frames_exp++;
      wait_frame(frames_exp, 200);
      cyc(4);
      chk("stop_reads", rd_cnt - base, BLK);
      chk("stop_en", int'(o_en), 0);
      chk("stop_busy", int'(o_busy), 0);
      base = rd_cnt;
      toggle();
      cyc(40);
      chk("stop_no_rd", rd_cnt - base, 0);

      // random gaps and random backpressure
      i_run = 1'b1;
      cyc(4);
      for (int b = 0; b < 4; b++) begin
         cyc($urandom_range(1, 15));
         base = rd_cnt;
         toggle();
         frames_exp++;
         for (int i = 0; i < 400 && int'(o_frame_cnt) != frames_exp; i++) begin
            i_fifo_afull = ($urandom_range(0, 2) == 0);
            cyc(1);
         end
         i_fifo_afull = 1'b0;
         chk("rnd_frame", int'(o_frame_cnt), frames_exp);
         chk("rnd_reads", rd_cnt - base, BLK);
      end
      chk("rnd_ovf", int'(o_ovf), 0);
      cyc(4);
      chk("final_sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ad_cache_rd_ctrl.md
AD_CACHE_RD_CTRL -- requirements
Module: ad_cache_rd_ctrl

Interface
REQ-001 SHALL have parameter HALF_WORDS, default 512: cache words per ping-pong half.
REQ-002 SHALL have parameter SUB_WORDS, default 3: 16-bit USB words per cache word.
REQ-003 SHALL have parameter RD_LAT, default 2: clk cycles from o_rd to the matching valid i_rdata.
REQ-004 SHALL have parameter SYNC_PERIOD, default 50000: o_sync period in clk cycles.
REQ-005 SHALL have parameter SYNC_WIDTH, default 4: o_sync high time in cycles, less than SYNC_PERIOD.
REQ-006 SHALL have port clk, input, 1: single clock (cache read side); all logic is on posedge clk.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port i_run, input, 1: acquisition enable request.
REQ-009 SHALL have port o_en, output, 1: cache enable.
REQ-010 SHALL have port o_sync, output, 1: cache SYNC.
REQ-011 SHALL have port i_switch, input, 1: cache half-switch indicator, already synchronous to clk.
REQ-012 SHALL have port o_rd, output, 1: cache read strobe.
REQ-013 SHALL have port i_rdata, input, 16: cache read data.
REQ-014 SHALL have port o_fifo_wr, output, 1: USB FIFO write strobe.
REQ-015 SHALL have port o_fifo_wdata, output, 16: USB FIFO write data.
REQ-016 SHALL have port i_fifo_afull, input, 1: FIFO almost-full; asserted while fewer than SUB_WORDS+RD_LAT+1 slots are free.
REQ-017 SHALL have port o_busy, output, 1: high while a block readout is in progress.
REQ-018 SHALL have port o_ovf, output, 1: sticky overrun flag.
REQ-019 SHALL have port i_ovf_clr, input, 1: clears o_ovf.
REQ-020 SHALL have port o_frame_cnt, output, 16: count of completed blocks.

Function
REQ-021 SHALL run a sync counter 0..SYNC_PERIOD-1 continuously after reset; o_sync=1 while counter<SYNC_WIDTH, registered.
REQ-022 SHALL register o_en <= i_run every cycle; the cache samples it at the next o_sync rise.
REQ-023 SHALL register i_switch once (sw_q); a switch event is the cycle where sw_q != i_switch.
REQ-024 SHALL implement states IDLE, ARM, BURST, CHECK and DRAIN.
REQ-025 IDLE SHALL go to ARM when o_en=1.
REQ-026 ARM SHALL go to BURST on a switch event and clear word_cnt and sub_cnt; with o_en=0 it SHALL go to IDLE.
REQ-027 BURST SHALL assert o_rd for exactly SUB_WORDS consecutive cycles (sub_cnt 0..SUB_WORDS-1), then go to CHECK.
REQ-028 CHECK SHALL increment word_cnt.
REQ-029 In CHECK, if word_cnt+1==HALF_WORDS the FSM SHALL go to DRAIN; otherwise if i_fifo_afull=0 it SHALL go to BURST, otherwise it SHALL stay in CHECK with o_rd=0.
REQ-030 Backpressure SHALL be honoured only in CHECK; a SUB_WORDS burst is never split.
REQ-031 DRAIN SHALL wait RD_LAT cycles, then pulse o_frame_cnt+1 (16-bit wrap) and go to ARM.
REQ-032 o_fifo_wr SHALL equal o_rd delayed by exactly RD_LAT cycles; o_fifo_wdata SHALL be i_rdata registered in that same cycle.
REQ-033 o_busy SHALL be 1 in BURST, CHECK and DRAIN.
REQ-034 A switch event in BURST, CHECK or DRAIN SHALL set o_ovf.
REQ-035 On such an event the FSM SHALL restart in BURST with word_cnt=0 and sub_cnt=0; in-flight o_fifo_wr pulses still complete and o_frame_cnt is not incremented.
REQ-036 If a switch event coincides with the last CHECK, the overrun rule SHALL take priority over DRAIN.
REQ-037 i_ovf_clr SHALL clear o_ovf; when it coincides with a set, the set SHALL win.
REQ-038 o_en falling mid-block SHALL not abort the block; the FSM finishes DRAIN, then goes ARM->IDLE.
REQ-039 Total o_rd pulses per completed block SHALL equal HALF_WORDS*SUB_WORDS.

Reset
REQ-040 When rst_n=0, all outputs and state SHALL go to 0 immediately: state=IDLE, sync counter=0, o_sync=0, o_en=0, o_rd=0, o_fifo_wr=0, o_ovf=0, o_frame_cnt=0, the delay pipe cleared, sw_q=0.
REQ-041 After rst_n deasserts, o_sync SHALL first rise on the 2nd clk edge.
REQ-042 Reset asserted mid-block SHALL discard the block without setting o_ovf.

Verification (HALF_WORDS=4, SUB_WORDS=3, RD_LAT=2, SYNC_PERIOD=20, SYNC_WIDTH=2)
REQ-043 Idle: i_run=0 for 100 cycles -> o_sync high 2 of every 20 cycles, o_en=0, o_rd never asserted.
REQ-044 Nominal: i_run=1, one switch toggle, afull=0 -> 12 o_rd pulses in 4 groups of 3, 12 o_fifo_wr pulses each 2 cycles after its o_rd, data matches i_rdata, o_frame_cnt=1, o_ovf=0.
REQ-045 Backpressure: afull=1 after the 2nd word for 10 cycles -> no o_rd during those cycles, no partial group, 12 total reads, o_frame_cnt=1.
REQ-046 Overrun: a second toggle after the 6th o_rd -> o_ovf=1, count restarts, 12 further reads, o_frame_cnt=1; i_ovf_clr=1 -> o_ovf=0 next cycle.
REQ-047 Reset mid-burst: rst_n=0 at the 5th o_rd -> all outputs 0 same cycle, state IDLE, o_ovf=0.
REQ-048 Stop: i_run dropped during word 2 -> block completes (12 reads), o_en=0, FSM in IDLE, a later toggle produces no o_rd.
